// File: rtl/iq_integrate_dump_if.sv
// rtl/iq_integrate_dump_if.sv - result channel of the I/Q integrate-and-dump block
//
// Carries one integrated I/Q result per handshake (m_valid && m_ready).
//   m_valid   : result held in the output register
//   m_ready   : consumer accepts the held result this cycle
//   m_data_i  : integrated I result, signed, ACC_WIDTH bits
//   m_data_q  : integrated Q result, signed, ACC_WIDTH bits
//   m_sat     : at least one accumulation step of this result's block clamped
interface iq_integrate_dump_if #(
    parameter int ACC_WIDTH = 40
);
    logic                 m_valid;
    logic                 m_ready;
    logic [ACC_WIDTH-1:0] m_data_i;
    logic [ACC_WIDTH-1:0] m_data_q;
    logic                 m_sat;

    modport master (
        output m_valid,
        output m_data_i,
        output m_data_q,
        output m_sat,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data_i,
        input  m_data_q,
        input  m_sat,
        output m_ready
    );
endinterface

// File: rtl/iq_integrate_dump.sv
// rtl/iq_integrate_dump.sv - lane-summing I/Q integrator with block dump to a valid/ready register
//
// Sums NUMBER_OF_LINE parallel signed 16-bit I/Q samples per clock, integrates
// the per-cycle sums with saturation over dump_length valid cycles, and dumps
// one result per block into a single-entry output register.
//
// Ports:
//   clock          : processing clock
//   reset          : synchronous, active-high
//   data_in_i/q    : lane k at bits [16k+15:16k], two's complement
//   data_in_valid  : qualifies data_in_i/q
//   dump_length    : valid cycles per block (0 behaves as 1), latched at block start
//   m              : result channel (m_valid/m_ready/m_data_i/m_data_q/m_sat)
//   overrun        : sticky, a result was dropped because the output was still full
//   clear_overrun  : clears overrun (a new overrun in the same cycle wins)
//
// Pipeline: S1 input register, S2 lane-sum register, S3 accumulator plus
// result register, then the output register (last sample at edge t gives
// m_valid after edge t+3).
module iq_integrate_dump #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int ACC_WIDTH      = 40
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [16*NUMBER_OF_LINE-1:0] data_in_i,
    input  logic [16*NUMBER_OF_LINE-1:0] data_in_q,
    input  logic                        data_in_valid,
    input  logic [15:0]                 dump_length,
    iq_integrate_dump_if.master         m,
    output logic                        overrun,
    input  logic                        clear_overrun
);

    localparam int DATA_W = 16 * NUMBER_OF_LINE;
    localparam int SUM_W  = 16 + $clog2(NUMBER_OF_LINE);
    localparam int EXT_W  = ACC_WIDTH + 1;

    // One extra bit so acc + sum never wraps before the clamp decision.
    localparam logic signed [EXT_W-1:0] SAT_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

    // S1
    logic [DATA_W-1:0] s1_i;
    logic [DATA_W-1:0] s1_q;
    logic              s1_valid;

    // S2
    logic signed [SUM_W-1:0] lane_sum_i;
    logic signed [SUM_W-1:0] lane_sum_q;
    logic signed [SUM_W-1:0] s2_sum_i;
    logic signed [SUM_W-1:0] s2_sum_q;
    logic                    s2_valid;

    // S3
    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [15:0]                 cnt;
    logic [15:0]                 len_latched;
    logic                        blk_sat;
    logic signed [EXT_W-1:0]     tot_i;
    logic signed [EXT_W-1:0]     tot_q;
    logic signed [ACC_WIDTH-1:0] sat_i;
    logic signed [ACC_WIDTH-1:0] sat_q;
    logic                        clamp_i;
    logic                        clamp_q;
    logic [15:0]                 cur_len;
    logic                        dump_now;

    // Result register between the accumulator and the output register
    logic                 res_valid;
    logic [ACC_WIDTH-1:0] res_i;
    logic [ACC_WIDTH-1:0] res_q;
    logic                 res_sat;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_i     <= '0;
            s1_q     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_i     <= data_in_i;
            s1_q     <= data_in_q;
            s1_valid <= data_in_valid;
        end
    end

    always_comb begin
        lane_sum_i = '0;
        lane_sum_q = '0;
        for (int k = 0; k < NUMBER_OF_LINE; k++) begin
            lane_sum_i = lane_sum_i + SUM_W'($signed(s1_i[16*k +: 16]));
            lane_sum_q = lane_sum_q + SUM_W'($signed(s1_q[16*k +: 16]));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_sum_i <= '0;
            s2_sum_q <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_sum_i <= lane_sum_i;
            s2_sum_q <= lane_sum_q;
            s2_valid <= s1_valid;
        end
    end

    always_comb begin
        tot_i   = EXT_W'(acc_i) + EXT_W'(s2_sum_i);
        tot_q   = EXT_W'(acc_q) + EXT_W'(s2_sum_q);
        sat_i   = tot_i[ACC_WIDTH-1:0];
        sat_q   = tot_q[ACC_WIDTH-1:0];
        clamp_i = 1'b0;
        clamp_q = 1'b0;
        if (tot_i > SAT_MAX) begin
            sat_i   = SAT_MAX[ACC_WIDTH-1:0];
            clamp_i = 1'b1;
        end else if (tot_i < SAT_MIN) begin
            sat_i   = SAT_MIN[ACC_WIDTH-1:0];
            clamp_i = 1'b1;
        end
        if (tot_q > SAT_MAX) begin
            sat_q   = SAT_MAX[ACC_WIDTH-1:0];
            clamp_q = 1'b1;
        end else if (tot_q < SAT_MIN) begin
            sat_q   = SAT_MIN[ACC_WIDTH-1:0];
            clamp_q = 1'b1;
        end
    end

    // The first sample of a block sees the live dump_length, later samples the
    // latched copy, so a block of length 1 dumps on its very first sample.
    always_comb begin
        if (cnt == 16'd0) begin
            cur_len = (dump_length == 16'd0) ? 16'd1 : dump_length;
        end else begin
            cur_len = len_latched;
        end
        dump_now = s2_valid && (cnt == cur_len - 16'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_i       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            len_latched <= '0;
            blk_sat     <= 1'b0;
            res_valid   <= 1'b0;
            res_i       <= '0;
            res_q       <= '0;
            res_sat     <= 1'b0;
        end else begin
            res_valid <= dump_now;
            if (s2_valid && (cnt == 16'd0)) begin
                len_latched <= cur_len;
            end
            if (dump_now) begin
                res_i   <= sat_i;
                res_q   <= sat_q;
                res_sat <= blk_sat | clamp_i | clamp_q;
                acc_i   <= '0;
                acc_q   <= '0;
                cnt     <= '0;
                blk_sat <= 1'b0;
            end else if (s2_valid) begin
                acc_i   <= sat_i;
                acc_q   <= sat_q;
                cnt     <= cnt + 16'd1;
                blk_sat <= blk_sat | clamp_i | clamp_q;
            end
        end
    end

    // A result arriving while the held one is not being taken is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            m.m_valid  <= 1'b0;
            m.m_data_i <= '0;
            m.m_data_q <= '0;
            m.m_sat    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (res_valid) begin
                if (!m.m_valid || m.m_ready) begin
                    m.m_valid  <= 1'b1;
                    m.m_data_i <= res_i;
                    m.m_data_q <= res_q;
                    m.m_sat    <= res_sat;
                end
            end else if (m.m_valid && m.m_ready) begin
                m.m_valid <= 1'b0;
            end

            if (res_valid && m.m_valid && !m.m_ready) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iq_integrate_dump.sv
// tb/tb_iq_integrate_dump.sv - randomized bench with a queue-based reference model for iq_integrate_dump
module tb_iq_integrate_dump;

    localparam int NL = 8;
    localparam int AW = 20;
    localparam int DW = 16 * NL;
    localparam longint LIM_MAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint LIM_MIN = -(64'sd1 <<< (AW - 1));

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in_i = '0;
    logic [DW-1:0] data_in_q = '0;
    logic          data_in_valid = 1'b0;
    logic [15:0]   dump_length = '0;
    logic          clear_overrun = 1'b0;
    logic          overrun;

    iq_integrate_dump_if #(.ACC_WIDTH(AW)) res_if ();

    iq_integrate_dump #(
        .NUMBER_OF_LINE(NL),
        .ACC_WIDTH     (AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in_i    (data_in_i),
        .data_in_q    (data_in_q),
        .data_in_valid(data_in_valid),
        .dump_length  (dump_length),
        .m            (res_if),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int edge_n = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Reference model: samples wait in a queue until the edge at which they
    // are integrated, results wait until the edge at which they are offered.
    typedef struct {
        int     due;
        longint si;
        longint sq;
    } samp_t;

    typedef struct {
        int     due;
        longint ri;
        longint rq;
        bit     rs;
    } res_t;

    samp_t  samp_q[$];
    res_t   res_q[$];
    longint acc_i, acc_q;
    int     cnt, blen;
    bit     bsat;
    bit     e_valid, e_sat, e_ovr;
    longint e_i, e_q;

    function automatic longint lane_sum(input logic [DW-1:0] v);
        longint s = 0;
        for (int k = 0; k < NL; k++) s += longint'($signed(v[16*k +: 16]));
        return s;
    endfunction

    function automatic longint clip(input longint x);
        if (x > LIM_MAX) return LIM_MAX;
        if (x < LIM_MIN) return LIM_MIN;
        return x;
    endfunction

    function automatic logic [DW-1:0] all_lanes(input logic [15:0] x);
        logic [DW-1:0] r;
        for (int k = 0; k < NL; k++) r[16*k +: 16] = x;
        return r;
    endfunction

    function automatic logic [DW-1:0] lane0(input logic [15:0] x);
        logic [DW-1:0] r = '0;
        r[15:0] = x;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_lanes();
        logic [DW-1:0] r;
        int mode = $urandom_range(0, 9);
        for (int k = 0; k < NL; k++) begin
            if (mode < 5)      r[16*k +: 16] = 16'($urandom_range(0, 8)) - 16'd4;
            else if (mode < 8) r[16*k +: 16] = 16'($urandom);
            else if (mode < 9) r[16*k +: 16] = 16'h7fff;
            else               r[16*k +: 16] = 16'h8000;
        end
        return r;
    endfunction

    task automatic model_edge();
        res_t   r;
        samp_t  s;
        bit     offered;
        bit     hit;
        longint ti, tq, ci, cq;
        edge_n++;
        if (reset) begin
            samp_q.delete();
            res_q.delete();
            acc_i = 0; acc_q = 0; cnt = 0; blen = 0; bsat = 0;
            e_valid = 0; e_sat = 0; e_ovr = 0; e_i = 0; e_q = 0;
            return;
        end
        offered = 0;
        if (res_q.size() != 0 && res_q[0].due == edge_n) begin
            r = res_q.pop_front();
            offered = 1;
        end
        if (offered && e_valid && !res_if.m_ready) e_ovr = 1;
        else if (clear_overrun) e_ovr = 0;
        if (offered) begin
            if (!e_valid || res_if.m_ready) begin
                e_valid = 1; e_i = r.ri; e_q = r.rq; e_sat = r.rs;
            end
        end else if (e_valid && res_if.m_ready) begin
            e_valid = 0;
        end
        if (samp_q.size() != 0 && samp_q[0].due == edge_n) begin
            s = samp_q.pop_front();
            if (cnt == 0) blen = (dump_length == 0) ? 1 : int'(dump_length);
            ti = acc_i + s.si;
            tq = acc_q + s.sq;
            ci = clip(ti);
            cq = clip(tq);
            hit = (ci != ti) || (cq != tq);
            if (cnt == blen - 1) begin
                res_q.push_back('{edge_n + 1, ci, cq, bsat | hit});
                acc_i = 0; acc_q = 0; cnt = 0; bsat = 0;
            end else begin
                acc_i = ci; acc_q = cq; cnt++; bsat = bsat | hit;
            end
        end
        if (data_in_valid) samp_q.push_back('{edge_n + 2, lane_sum(data_in_i), lane_sum(data_in_q)});
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] di, input logic [DW-1:0] dq,
                         input logic [15:0] dl, input bit rdy, input bit clr, input bit rst);
        data_in_valid  = v;
        data_in_i      = di;
        data_in_q      = dq;
        dump_length    = dl;
        res_if.m_ready = rdy;
        clear_overrun  = clr;
        reset          = rst;
        model_edge();
        @(posedge clock);
        #1;
        check_val("m_valid",  longint'(res_if.m_valid), longint'(e_valid));
        check_val("m_data_i", longint'($signed(res_if.m_data_i)), e_i);
        check_val("m_data_q", longint'($signed(res_if.m_data_q)), e_q);
        check_val("m_sat",    longint'(res_if.m_sat), longint'(e_sat));
        check_val("overrun",  longint'(overrun), longint'(e_ovr));
    endtask

    task automatic idle(input int n, input logic [15:0] dl, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, dl, rdy, 0, 0);
    endtask

    logic [DW-1:0] lanes_a, lanes_b;
    logic [15:0]   dl_r;
    bit            pat[6] = '{1, 0, 0, 1, 0, 1};

    initial begin
        res_if.m_ready = 1'b0;
        // Reset state
        for (int i = 0; i < 3; i++) cycle(0, '0, '0, 16'd0, 0, 0, 1);

        // Basic sum: 8 lanes of +100 / -50, length 4
        lanes_a = all_lanes(16'd100);
        lanes_b = all_lanes(-16'sd50);
        for (int i = 0; i < 12; i++) cycle(1, lanes_a, lanes_b, 16'd4, 1, 0, 0);
        idle(5, 16'd4, 1);

        // Gapped valid, length 3, lane0 I=1
        for (int i = 0; i < 6; i++) cycle(pat[i], lane0(16'd1), '0, 16'd3, 1, 0, 0);
        idle(5, 16'd3, 1);

        // Saturation then recovery, length 16
        for (int i = 0; i < 16; i++) cycle(1, all_lanes(16'h7fff), '0, 16'd16, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(1, all_lanes(16'd1), '0, 16'd16, 1, 0, 0);
        idle(5, 16'd16, 1);

        // Backpressure and overrun, length 1
        cycle(1, lane0(16'd8), '0, 16'd1, 0, 0, 0);
        cycle(1, lane0(16'd16), '0, 16'd1, 0, 0, 0);
        idle(4, 16'd1, 0);
        idle(1, 16'd1, 1);
        cycle(0, '0, '0, 16'd1, 1, 1, 0);
        idle(2, 16'd1, 1);

        // dump_length change mid-block, then zero
        for (int i = 0; i < 3; i++) cycle(1, lane0(16'd2), lane0(16'd3), 16'd4, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(1, lane0(16'd2), lane0(16'd3), 16'd2, 1, 0, 0);
        idle(4, 16'd2, 1);
        for (int i = 0; i < 5; i++) cycle(1, lane0(16'(i + 1)), '0, 16'd0, 1, 0, 0);
        idle(5, 16'd0, 1);

        // Reset mid-block, length 8
        for (int i = 0; i < 5; i++) cycle(1, all_lanes(16'd1), '0, 16'd8, 1, 0, 0);
        cycle(0, '0, '0, 16'd8, 1, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, all_lanes(16'd1), '0, 16'd8, 1, 0, 0);
        idle(5, 16'd8, 1);

        // Randomized traffic
        dl_r = 16'd2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) dl_r = 16'($urandom_range(0, 5));
            cycle($urandom_range(0, 9) < 7, rand_lanes(), rand_lanes(), dl_r,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 399) == 0);
        end
        idle(6, dl_r, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
